// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: deals four cards, applies the third-card rules,
// scores both hands and holds endround high once the round is decided.
module baccarat_round_ctrl (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] new_card,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       endround,
    output logic [3:0] o_dbg_state
);

    typedef enum logic [3:0] {
        S_P1   = 4'd0,
        S_D1   = 4'd1,
        S_P2   = 4'd2,
        S_D2   = 4'd3,
        S_CHK  = 4'd4,
        S_P3   = 4'd5,
        S_BCHK = 4'd6,
        S_D3   = 4'd7,
        S_END  = 4'd8
    } state_t;

    state_t     r_state;
    logic [3:0] r_pcard1, r_pcard2, r_pcard3;
    logic [3:0] r_dcard1, r_dcard2, r_dcard3;
    logic       r_endround;
    logic [3:0] w_ps, w_ds, w_t;
    logic       w_banker_draws;

    function automatic logic [3:0] card_val(input logic [3:0] c);
        return ((c >= 4'd1) && (c <= 4'd9)) ? c : 4'd0;
    endfunction

    // Sum is at most 27, so subtracting 10 or 20 once gives mod 10.
    function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] s;
        s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
        if (s >= 5'd20)
            s = s - 5'd20;
        else if (s >= 5'd10)
            s = s - 5'd10;
        return s[3:0];
    endfunction

    assign w_ps = hand_score(r_pcard1, r_pcard2, r_pcard3);
    assign w_ds = hand_score(r_dcard1, r_dcard2, r_dcard3);
    assign w_t  = card_val(r_pcard3);

    always_comb begin
        w_banker_draws = 1'b0;
        case (w_ds)
            4'd0, 4'd1, 4'd2: w_banker_draws = 1'b1;
            4'd3:             w_banker_draws = (w_t != 4'd8);
            4'd4:             w_banker_draws = (w_t >= 4'd2) && (w_t <= 4'd7);
            4'd5:             w_banker_draws = (w_t >= 4'd4) && (w_t <= 4'd7);
            4'd6:             w_banker_draws = (w_t >= 4'd6) && (w_t <= 4'd7);
            default:          w_banker_draws = 1'b0;
        endcase
    end

    // step acts as the advance strobe: a card is consumed on every rising edge
    // where step=1 in a dealing state; CHK and BCHK proceed without it.
    always_ff @(posedge slow_clock) begin
        if (!reset) begin
            r_state    <= S_P1;
            r_pcard1   <= 4'd0;
            r_pcard2   <= 4'd0;
            r_pcard3   <= 4'd0;
            r_dcard1   <= 4'd0;
            r_dcard2   <= 4'd0;
            r_dcard3   <= 4'd0;
            r_endround <= 1'b0;
        end else begin
            case (r_state)
                S_P1: if (step) begin r_pcard1 <= new_card; r_state <= S_D1; end
                S_D1: if (step) begin r_dcard1 <= new_card; r_state <= S_P2; end
                S_P2: if (step) begin r_pcard2 <= new_card; r_state <= S_D2; end
                S_D2: if (step) begin r_dcard2 <= new_card; r_state <= S_CHK; end
                S_CHK: begin
                    if ((w_ps >= 4'd8) || (w_ds >= 4'd8)) begin
                        r_state    <= S_END;
                        r_endround <= 1'b1;
                    end else if (w_ps <= 4'd5) begin
                        r_state <= S_P3;
                    end else if (w_ds <= 4'd5) begin
                        r_state <= S_D3;
                    end else begin
                        r_state    <= S_END;
                        r_endround <= 1'b1;
                    end
                end
                S_P3: if (step) begin r_pcard3 <= new_card; r_state <= S_BCHK; end
                S_BCHK: begin
                    if (w_banker_draws) begin
                        r_state <= S_D3;
                    end else begin
                        r_state    <= S_END;
                        r_endround <= 1'b1;
                    end
                end
                S_D3: begin
                    if (step) begin
                        r_dcard3   <= new_card;
                        r_state    <= S_END;
                        r_endround <= 1'b1;
                    end
                end
                S_END: r_endround <= 1'b1;
                default: begin
                    r_state    <= S_P1;
                    r_endround <= 1'b0;
                end
            endcase
        end
    end

    assign pcard1      = r_pcard1;
    assign pcard2      = r_pcard2;
    assign pcard3      = r_pcard3;
    assign dcard1      = r_dcard1;
    assign dcard2      = r_dcard2;
    assign dcard3      = r_dcard3;
    assign pscore      = w_ps;
    assign dscore      = w_ds;
    assign endround    = r_endround;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Directed bench for baccarat_round_ctrl: rounds are dealt from hand-computed
// vectors; a monitor scores the hand snapshot on each rising endround.
module tb_baccarat_round_ctrl;

    logic       slow_clock;
    logic       reset;
    logic       step;
    logic [3:0] new_card;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic       endround;
    logic [3:0] o_dbg_state;

    logic [31:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    logic prev_end = 1'b0;

    baccarat_round_ctrl dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .step       (step),
        .new_card   (new_card),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .pscore     (pscore),
        .dscore     (dscore),
        .endround   (endround),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Snapshot order: pcard1,pcard2,pcard3,dcard1,dcard2,dcard3,pscore,dscore
    function automatic logic [31:0] dut_vec();
        return {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge slow_clock) begin
        if (endround && !prev_end) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_endround: got %h expected none", dut_vec());
            end else begin
                check("round_result", dut_vec(), exp_q.pop_front());
            end
        end
        prev_end = endround;
    end

    // driver tasks
    task automatic do_reset();
        @(negedge slow_clock);
        reset = 1'b0;
        step  = 1'b0;
        @(negedge slow_clock);
        reset = 1'b1;
    endtask

    task automatic deal(input logic [3:0] c);
        @(negedge slow_clock);
        step     = 1'b1;
        new_card = c;
        @(negedge slow_clock);
        step     = 1'b0;
        new_card = 4'd15;
    endtask

    task automatic wait_end(input string name, input int lat);
        int n;
        n = 0;
        while (!endround && n < 20) begin
            @(negedge slow_clock);
            n++;
        end
        check(name, n, lat);
    endtask

    task automatic run_round(input string name, input logic [3:0] c0, input logic [3:0] c1,
                             input logic [3:0] c2, input logic [3:0] c3, input logic [3:0] c4,
                             input logic [3:0] c5, input int n, input logic [31:0] exp,
                             input int lat);
        logic [3:0] cards[6];
        cards = '{c0, c1, c2, c3, c4, c5};
        do_reset();
        exp_q.push_back(exp);
        for (int i = 0; i < n; i++) deal(cards[i]);
        wait_end(name, lat);
    endtask

    initial begin
        reset    = 1'b0;
        step     = 1'b0;
        new_card = 4'd0;
        repeat (2) @(negedge slow_clock);
        check("reset_cards", dut_vec(), 32'h0);
        check("reset_endround", {31'd0, endround}, 32'd0);
        check("reset_state", {28'd0, o_dbg_state}, 32'd0);
        reset = 1'b1;

        run_round("natural_wrap",   4'd9, 4'd13, 4'd9, 4'd12, 4'd0, 4'd0, 4, 32'h99_0_DC_0_8_0, 1);
        run_round("banker_7_stand", 4'd2, 4'd3,  4'd3, 4'd4,  4'd10, 4'd0, 5, 32'h23_A_34_0_5_7, 1);
        run_round("player_stands",  4'd1, 4'd2,  4'd5, 4'd2,  4'd9, 4'd0, 5, 32'h15_0_22_9_6_3, 0);
        run_round("banker3_vs_8",   4'd1, 4'd1,  4'd1, 4'd2,  4'd8, 4'd0, 5, 32'h11_8_12_0_0_3, 1);
        run_round("banker6_draw",   4'd3, 4'd4,  4'd2, 4'd2,  4'd7, 4'd5, 6, 32'h32_7_42_5_2_1, 0);
        run_round("banker6_stand",  4'd3, 4'd4,  4'd2, 4'd2,  4'd5, 4'd0, 5, 32'h32_5_42_0_0_6, 1);
        run_round("banker5_t3",     4'd1, 4'd2,  4'd2, 4'd3,  4'd3, 4'd0, 5, 32'h12_3_23_0_6_5, 1);
        run_round("banker4_t2",     4'd2, 4'd1,  4'd2, 4'd3,  4'd2, 4'd4, 6, 32'h22_2_13_4_6_8, 0);

        // step gating in D1, then reset mid-deal in P2
        do_reset();
        deal(4'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge slow_clock);
            new_card = 4'(i + 1);
        end
        check("hold_d1_cards", dut_vec(), 32'h50_0_00_0_5_0);
        check("hold_d1_state", {28'd0, o_dbg_state}, 32'd1);
        deal(4'd7);
        check("p2_state", {28'd0, o_dbg_state}, 32'd2);
        @(negedge slow_clock);
        reset    = 1'b0;
        step     = 1'b1;
        new_card = 4'd3;
        @(negedge slow_clock);
        check("midreset_cards", dut_vec(), 32'h0);
        check("midreset_state", {28'd0, o_dbg_state}, 32'd0);
        check("midreset_endround", {31'd0, endround}, 32'd0);
        reset = 1'b1;
        step  = 1'b0;

        // END ignores step; reset is the only exit
        exp_q.push_back(32'h99_0_DC_0_8_0);
        deal(4'd9); deal(4'd13); deal(4'd9); deal(4'd12);
        wait_end("end_hold_latency", 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge slow_clock);
            step     = ~step;
            new_card = 4'd7;
        end
        @(negedge slow_clock);
        step = 1'b0;
        check("end_frozen_cards", dut_vec(), 32'h99_0_DC_0_8_0);
        check("end_frozen_state", {28'd0, o_dbg_state}, 32'd8);
        check("end_frozen_endround", {31'd0, endround}, 32'd1);
        do_reset();
        check("end_reset_endround", {31'd0, endround}, 32'd0);
        check("end_reset_cards", dut_vec(), 32'h0);

        repeat (2) @(negedge slow_clock);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
